// File: rtl/axi_lite_master.sv
// axi_lite_master
//   Turns single register-access commands into AXI4-Lite transactions.
//   Only one transaction is outstanding at a time. Each transaction ends with
//   exactly one completion on the rsp_* interface. If the slave stalls for
//   TIMEOUT cycles, the completion carries response code 2'b11.
//
// Ports
//   axi_clk, axi_rstn                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready                command handshake
//   cmd_write, cmd_addr, cmd_wdata     command payload
//   rsp_valid/rsp_ready                completion handshake
//   rsp_write, rsp_rdata, rsp_resp     completion payload
//   AW: axi_write_addr, write_addr_valid/ready
//   W : axi_write_data, write_data_valid/ready
//   B : axi_write_resp, write_resp_valid/ready
//   AR: axi_read_addr_o, read_addr_valid_o/read_addr_ready_i
//   R : axi_read_data_i, read_resp_i, read_data_valid_i/read_data_ready_o
module axi_lite_master #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  axi_clk,
  input  logic                  axi_rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ADDR_WIDTH-1:0] axi_write_addr,
  output logic                  write_addr_valid,
  input  logic                  write_addr_ready,
  output logic [DATA_WIDTH-1:0] axi_write_data,
  output logic                  write_data_valid,
  input  logic                  write_data_ready,
  input  logic [1:0]            axi_write_resp,
  input  logic                  write_resp_valid,
  output logic                  write_resp_ready,
  output logic [ADDR_WIDTH-1:0] axi_read_addr_o,
  output logic                  read_addr_valid_o,
  input  logic                  read_addr_ready_i,
  input  logic [DATA_WIDTH-1:0] axi_read_data_i,
  input  logic                  read_data_valid_i,
  output logic                  read_data_ready_o,
  input  logic [1:0]            read_resp_i
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP
  } state_e;

  localparam logic [1:0]  RESP_TIMEOUT = 2'b11;
  // The counter value seen in the last cycle allowed without a handshake.
  localparam logic [15:0] CNT_LAST     = 16'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs, waiting, timeout;

  // All handshake-facing outputs are decoded from registered state only, so
  // address/data are stable for as long as the matching valid is high.
  assign cmd_ready         = (state_q == IDLE);
  assign write_addr_valid  = (state_q == WR_ADDR_DATA) && !aw_done_q;
  assign write_data_valid  = (state_q == WR_ADDR_DATA) && !w_done_q;
  assign write_resp_ready  = (state_q == WR_RESP);
  assign read_addr_valid_o = (state_q == RD_ADDR);
  assign read_data_ready_o = (state_q == RD_DATA);
  assign rsp_valid         = (state_q == RESP);
  assign axi_write_addr    = addr_q;
  assign axi_write_data    = wdata_q;
  assign axi_read_addr_o   = addr_q;
  assign rsp_write         = rsp_write_q;
  assign rsp_rdata         = rsp_rdata_q;
  assign rsp_resp          = rsp_resp_q;

  assign aw_hs  = write_addr_valid  & write_addr_ready;
  assign w_hs   = write_data_valid  & write_data_ready;
  assign b_hs   = write_resp_ready  & write_resp_valid;
  assign ar_hs  = read_addr_valid_o & read_addr_ready_i;
  assign r_hs   = read_data_ready_o & read_data_valid_i;
  assign any_hs = aw_hs | w_hs | b_hs | ar_hs | r_hs;

  assign waiting = (state_q == WR_ADDR_DATA) || (state_q == WR_RESP) ||
                   (state_q == RD_ADDR)      || (state_q == RD_DATA);
  // A handshake in the final allowed cycle still wins over the timeout.
  assign timeout = waiting && !any_hs && (cnt_q == CNT_LAST);

  always_comb begin
    // NOTE: every variable gets a hold value first, so no path leaves one unassigned (no latches).
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    cnt_d       = cnt_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          rsp_write_d = cmd_write;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          cnt_d       = '0;
          state_d     = cmd_write ? WR_ADDR_DATA : RD_ADDR;
        end
      end
      WR_ADDR_DATA: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        // AW and W may finish in either order or in the same cycle.
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (b_hs) begin
          rsp_resp_d  = axi_write_resp;
          rsp_rdata_d = '0;
          rsp_write_d = 1'b1;
          state_d     = RESP;
        end
      end
      RD_ADDR: begin
        if (ar_hs) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (r_hs) begin
          rsp_rdata_d = axi_read_data_i;
          rsp_resp_d  = read_resp_i;
          rsp_write_d = 1'b0;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The wait counter measures slave silence, so any handshake restarts it.
    if (waiting) cnt_d = any_hs ? '0 : cnt_q + 16'd1;

    if (timeout) begin
      rsp_resp_d  = RESP_TIMEOUT;
      rsp_rdata_d = '0;
      cnt_d       = '0;
      state_d     = RESP;
    end
  end

  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      cnt_q       <= '0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      cnt_q       <= cnt_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master
//   Self-checking bench for axi_lite_master (TIMEOUT = 8). A cycle-level AXI
//   slave with per-channel delays answers the DUT. Directed vectors come from a
//   table of hand-derived expectations. Random transactions are compared
//   against a register-file reference model. A hand-written sequence pulses
//   reset while the DUT waits for a write response.
module tb_axi_lite_master;

  localparam int T     = 8;
  localparam int NEVER = 1000;  // delay value meaning "slave never answers"

  logic        axi_clk = 1'b0;
  logic        axi_rstn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [1:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [1:0]  axi_write_addr;
  logic        write_addr_valid, write_addr_ready = 1'b0;
  logic [31:0] axi_write_data;
  logic        write_data_valid, write_data_ready = 1'b0;
  logic [1:0]  axi_write_resp = '0;
  logic        write_resp_valid = 1'b0, write_resp_ready;
  logic [1:0]  axi_read_addr_o;
  logic        read_addr_valid_o, read_addr_ready_i = 1'b0;
  logic [31:0] axi_read_data_i = '0;
  logic        read_data_valid_i = 1'b0, read_data_ready_o;
  logic [1:0]  read_resp_i = '0;

  axi_lite_master #(.ADDR_WIDTH(2), .DATA_WIDTH(32), .TIMEOUT(T)) dut (
    .axi_clk(axi_clk), .axi_rstn(axi_rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .axi_write_addr(axi_write_addr), .write_addr_valid(write_addr_valid),
    .write_addr_ready(write_addr_ready),
    .axi_write_data(axi_write_data), .write_data_valid(write_data_valid),
    .write_data_ready(write_data_ready),
    .axi_write_resp(axi_write_resp), .write_resp_valid(write_resp_valid),
    .write_resp_ready(write_resp_ready),
    .axi_read_addr_o(axi_read_addr_o), .read_addr_valid_o(read_addr_valid_o),
    .read_addr_ready_i(read_addr_ready_i),
    .axi_read_data_i(axi_read_data_i), .read_data_valid_i(read_data_valid_i),
    .read_data_ready_o(read_data_ready_o), .read_resp_i(read_resp_i)
  );

  always #5 axi_clk = ~axi_clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] slave_mem [4];  // storage inside the bench's AXI slave
  logic [31:0] ref_mem   [4];  // reference model of the register file

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    int          aw_d, w_d, b_d, ar_d, r_d;   // slave delays in cycles
    logic [1:0]  code;                        // B/R response the slave returns
    int          rsp_d;                       // cycles rsp_ready is held low
    logic [1:0]  e_resp;
    logic [31:0] e_rdata;
    logic        e_write;
    int          e_aw, e_w, e_b, e_ar, e_r;   // cycles each valid/ready is high
  } vec_t;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        write;
    int          aw_cyc, w_cyc, b_cyc, ar_cyc, r_cyc;
    bit          done, addr_bad, data_bad, hold_bad;
  } obs_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one command and plays the slave side until the completion is
  // consumed (or a 200-cycle budget runs out).
  task automatic run_txn(input logic wr, input logic [1:0] addr, input logic [31:0] wdata,
                         input int aw_d, input int w_d, input int b_d, input int ar_d,
                         input int r_d, input logic [1:0] code, input int rsp_d,
                         output obs_t o);
    int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0, hold = 0;
    bit aw_got = 0, w_got = 0, b_got = 0, ar_got = 0, r_got = 0, committed = 0, seen = 0;
    logic [1:0]  aw_addr = '0, ar_addr = '0;
    logic [31:0] w_data = '0;
    o.resp = '0; o.rdata = '0; o.write = 1'b0;
    o.aw_cyc = 0; o.w_cyc = 0; o.b_cyc = 0; o.ar_cyc = 0; o.r_cyc = 0;
    o.done = 0; o.addr_bad = 0; o.data_bad = 0; o.hold_bad = 0;

    @(negedge axi_clk);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    @(negedge axi_clk);
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 2'($urandom); cmd_wdata = $urandom;
    check("cmd_ready_after_accept", cmd_ready, 0);

    for (int cyc = 0; cyc < 200 && !o.done; cyc++) begin
      if (cyc != 0) @(negedge axi_clk);
      // Response channels use flags from earlier cycles only.
      write_resp_valid = aw_got && w_got && !b_got && (b_wait >= b_d);
      if (aw_got && w_got && !b_got) b_wait++;
      axi_write_resp = code;
      if (write_resp_ready) o.b_cyc++;
      if (write_resp_valid && write_resp_ready) b_got = 1;

      read_data_valid_i = ar_got && !r_got && (r_wait >= r_d);
      if (ar_got && !r_got) r_wait++;
      axi_read_data_i = read_data_valid_i ? slave_mem[ar_addr] : $urandom;
      read_resp_i     = read_data_valid_i ? code : 2'($urandom);
      if (read_data_ready_o) o.r_cyc++;
      if (read_data_valid_i && read_data_ready_o) r_got = 1;

      write_addr_ready = 1'b0;
      if (write_addr_valid) begin
        o.aw_cyc++;
        if (axi_write_addr !== addr) o.addr_bad = 1;
        write_addr_ready = !aw_got && (aw_wait >= aw_d);
        aw_wait++;
        if (write_addr_ready) begin aw_got = 1; aw_addr = axi_write_addr; end
      end
      write_data_ready = 1'b0;
      if (write_data_valid) begin
        o.w_cyc++;
        if (axi_write_data !== wdata) o.data_bad = 1;
        write_data_ready = !w_got && (w_wait >= w_d);
        w_wait++;
        if (write_data_ready) begin w_got = 1; w_data = axi_write_data; end
      end
      if (aw_got && w_got && !committed) begin
        slave_mem[aw_addr] = w_data;
        committed = 1;
      end
      read_addr_ready_i = 1'b0;
      if (read_addr_valid_o) begin
        o.ar_cyc++;
        if (axi_read_addr_o !== addr) o.addr_bad = 1;
        read_addr_ready_i = !ar_got && (ar_wait >= ar_d);
        ar_wait++;
        if (read_addr_ready_i) begin ar_got = 1; ar_addr = axi_read_addr_o; end
      end

      rsp_ready = 1'b0;
      if (rsp_valid) begin
        if (!seen) begin
          seen = 1; o.resp = rsp_resp; o.rdata = rsp_rdata; o.write = rsp_write;
        end else if ({rsp_resp, rsp_rdata, rsp_write} !== {o.resp, o.rdata, o.write}) begin
          o.hold_bad = 1;
        end
        if (cmd_ready) o.hold_bad = 1;
        rsp_ready = (hold >= rsp_d);
        hold++;
        if (rsp_ready) o.done = 1;
      end
    end

    @(negedge axi_clk);
    rsp_ready = 1'b0; write_resp_valid = 1'b0; read_data_valid_i = 1'b0;
    write_addr_ready = 1'b0; write_data_ready = 1'b0; read_addr_ready_i = 1'b0;
    check("idle_after_rsp.cmd_ready", cmd_ready, 1);
    check("idle_after_rsp.rsp_valid", rsp_valid, 0);
  endtask

  task automatic check_obs(input string tag, input obs_t o, input logic [1:0] e_resp,
                           input logic [31:0] e_rdata, input logic e_write, input int e_aw,
                           input int e_w, input int e_b, input int e_ar, input int e_r);
    check({tag, ".completed"}, o.done, 1);
    check({tag, ".rsp_resp"}, o.resp, e_resp);
    check({tag, ".rsp_rdata"}, o.rdata, e_rdata);
    check({tag, ".rsp_write"}, o.write, e_write);
    check({tag, ".aw_valid_cycles"}, o.aw_cyc, e_aw);
    check({tag, ".w_valid_cycles"}, o.w_cyc, e_w);
    check({tag, ".b_ready_cycles"}, o.b_cyc, e_b);
    check({tag, ".ar_valid_cycles"}, o.ar_cyc, e_ar);
    check({tag, ".r_ready_cycles"}, o.r_cyc, e_r);
    check({tag, ".addr_stable"}, o.addr_bad, 0);
    check({tag, ".wdata_stable"}, o.data_bad, 0);
    check({tag, ".rsp_hold"}, o.hold_bad, 0);
  endtask

  vec_t        vecs [11];
  obs_t        obs;
  logic        r_wr;
  logic [1:0]  r_addr, r_code;
  logic [31:0] r_data;
  int          r_aw, r_w, r_b, r_ar, r_r, r_hold;

  initial begin
    for (int i = 0; i < 4; i++) begin slave_mem[i] = '0; ref_mem[i] = '0; end

    //          wr addr wdata     aw w  b      ar     r      code  hold  resp  rdata     wr  aw w  b  ar r
    vecs[0]  = '{1, 3, 1234,     0, 0, 0,     0,     0,     2'd0, 0,    2'd0, 0,        1,  1, 1, 1, 0, 0};
    vecs[1]  = '{1, 1, 'hCAFE,   0, 4, 2,     0,     0,     2'd0, 1,    2'd0, 0,        1,  1, 5, 3, 0, 0};
    vecs[2]  = '{0, 3, 0,        0, 0, 0,     0,     0,     2'd0, 0,    2'd0, 1234,     0,  0, 0, 0, 1, 1};
    vecs[3]  = '{0, 2, 0,        0, 0, 0,     NEVER, 0,     2'd0, 0,    2'd3, 0,        0,  0, 0, 0, T, 0};
    vecs[4]  = '{1, 2, 'h55AA,   2, 0, 0,     0,     0,     2'd2, 0,    2'd2, 0,        1,  3, 1, 1, 0, 0};
    vecs[5]  = '{0, 1, 0,        0, 0, 0,     3,     4,     2'd3, 0,    2'd3, 'hCAFE,   0,  0, 0, 0, 4, 5};
    vecs[6]  = '{0, 2, 0,        0, 0, 0,     0,     0,     2'd1, 6,    2'd1, 'h55AA,   0,  0, 0, 0, 1, 1};
    vecs[7]  = '{1, 0, 'hDEAD,   1, 1, NEVER, 0,     0,     2'd0, 0,    2'd3, 0,        1,  2, 2, T, 0, 0};
    vecs[8]  = '{0, 0, 0,        0, 0, 0,     1,     NEVER, 2'd0, 0,    2'd3, 0,        0,  0, 0, 0, 2, T};
    // W stalls after AW completes: the AW handshake restarts the wait count.
    vecs[9]  = '{1, 3, 'h1111,   0, NEVER, 0, 0,     0,     2'd0, 0,    2'd3, 0,        1,  1, 1+T, 0, 0, 0};
    vecs[10] = '{0, 0, 0,        0, 0, 0,     0,     0,     2'd0, 2,    2'd0, 'hDEAD,   0,  0, 0, 0, 1, 1};

    // Reset state, held with cmd_valid asserted.
    cmd_valid = 1'b1;
    repeat (2) @(negedge axi_clk);
    check("reset.cmd_ready", cmd_ready, 1);
    check("reset.valids_readies",
          {write_addr_valid, write_data_valid, write_resp_ready, read_addr_valid_o,
           read_data_ready_o, rsp_valid, rsp_write}, 0);
    check("reset.rsp_rdata", rsp_rdata, 0);
    check("reset.rsp_resp", rsp_resp, 0);
    check("reset.addr_data", {axi_write_addr, axi_read_addr_o, axi_write_data}, 0);
    cmd_valid = 1'b0;
    axi_rstn  = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].aw_d, vecs[i].w_d, vecs[i].b_d,
              vecs[i].ar_d, vecs[i].r_d, vecs[i].code, vecs[i].rsp_d, obs);
      check_obs($sformatf("vec%0d", i), obs, vecs[i].e_resp, vecs[i].e_rdata, vecs[i].e_write,
                vecs[i].e_aw, vecs[i].e_w, vecs[i].e_b, vecs[i].e_ar, vecs[i].e_r);
    end

    // Register contents implied by the table: completed writes land, the
    // write whose W never handshook does not.
    ref_mem[0] = 32'hDEAD; ref_mem[1] = 32'hCAFE; ref_mem[2] = 32'h55AA; ref_mem[3] = 32'd1234;

    for (int i = 0; i < 40; i++) begin
      r_wr   = 1'($urandom);
      r_addr = 2'($urandom);
      r_data = $urandom;
      r_code = 2'($urandom);
      r_aw   = $urandom_range(0, 5); r_w = $urandom_range(0, 5); r_b = $urandom_range(0, 5);
      r_ar   = $urandom_range(0, 5); r_r = $urandom_range(0, 5); r_hold = $urandom_range(0, 3);
      run_txn(r_wr, r_addr, r_data, r_aw, r_w, r_b, r_ar, r_r, r_code, r_hold, obs);
      check_obs($sformatf("rand%0d", i), obs, r_code, r_wr ? 32'd0 : ref_mem[r_addr], r_wr,
                r_wr ? r_aw + 1 : 0, r_wr ? r_w + 1 : 0, r_wr ? r_b + 1 : 0,
                r_wr ? 0 : r_ar + 1, r_wr ? 0 : r_r + 1);
      if (r_wr) ref_mem[r_addr] = r_data;
    end

    // Reset pulse while waiting for B.
    @(negedge axi_clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd2; cmd_wdata = 32'h0BAD_F00D;
    write_addr_ready = 1'b1; write_data_ready = 1'b1;
    @(negedge axi_clk);
    cmd_valid = 1'b0;
    check("rst_seq.aw_valid", write_addr_valid, 1);
    check("rst_seq.w_valid", write_data_valid, 1);
    @(negedge axi_clk);
    write_addr_ready = 1'b0; write_data_ready = 1'b0;
    slave_mem[2] = 32'h0BAD_F00D;
    ref_mem[2]   = 32'h0BAD_F00D;
    check("rst_seq.in_wr_resp", write_resp_ready, 1);
    #2 axi_rstn = 1'b0;
    #1;
    check("rst_seq.async.cmd_ready", cmd_ready, 1);
    check("rst_seq.async.valids_readies",
          {write_addr_valid, write_data_valid, write_resp_ready, read_addr_valid_o,
           read_data_ready_o, rsp_valid}, 0);
    @(negedge axi_clk);
    axi_rstn = 1'b1;
    run_txn(1'b0, 2'd2, 32'd0, 0, 0, 0, 1, 2, 2'd0, 0, obs);
    check_obs("rst_seq.read", obs, 2'd0, ref_mem[2], 1'b0, 0, 0, 0, 2, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 2, AXI address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, AXI data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, maximum slave wait cycles per transaction (range 1..65535).
REQ-004 The block SHALL have the following ports, one per line:
- axi_clk  in  1  sole clock; all logic on rising edge
- axi_rstn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target register address
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  completion available
- rsp_ready  in  1  completion consumed
- rsp_write  out  1  completion belongs to a write
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and timeouts)
- rsp_resp  out  2  AXI response code, or 2'b11 on timeout
- axi_write_addr  out  ADDR_WIDTH  AW address
- write_addr_valid / write_addr_ready  out / in  1  AW handshake
- axi_write_data  out  DATA_WIDTH  W data
- write_data_valid / write_data_ready  out / in  1  W handshake
- axi_write_resp  in  2  B response
- write_resp_valid / write_resp_ready  in / out  1  B handshake
- axi_read_addr_o  out  ADDR_WIDTH  AR address
- read_addr_valid_o / read_addr_ready_i  out / in  1  AR handshake
- axi_read_data_i  in  DATA_WIDTH  R data
- read_data_valid_i / read_data_ready_o  in / out  1  R handshake
- read_resp_i  in  2  R response

Function
REQ-005 The FSM SHALL have states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP; one transaction is outstanding at a time.
REQ-006 cmd_ready SHALL be high only in IDLE; a handshake there SHALL register cmd_addr/cmd_wdata/cmd_write and move to WR_ADDR_DATA (write) or RD_ADDR (read).
REQ-007 In WR_ADDR_DATA, write_addr_valid and write_data_valid SHALL both rise in the cycle after acceptance; each SHALL drop independently on the cycle after its own valid&ready; the state SHALL move to WR_RESP once both handshakes are done, including both in the same cycle.
REQ-008 AW/W/AR address and data outputs SHALL remain stable while their valid is high.
REQ-009 write_resp_ready SHALL be high only in WR_RESP; on write_resp_valid it SHALL capture axi_write_resp into rsp_resp, set rsp_rdata=0 and rsp_write=1, and go to RESP.
REQ-010 In RD_ADDR, read_addr_valid_o SHALL be high until read_addr_ready_i, then the state SHALL move to RD_DATA.
REQ-011 read_data_ready_o SHALL be high only in RD_DATA; on read_data_valid_i it SHALL capture axi_read_data_i and read_resp_i, set rsp_write=0, and go to RESP.
REQ-012 In RESP, rsp_valid SHALL be high and rsp_* stable until rsp_ready; on that handshake the state SHALL return to IDLE. A new command is not accepted in the same cycle.
REQ-013 A wait counter SHALL clear on command acceptance and on every AXI handshake, and SHALL increment each cycle in WR_ADDR_DATA, WR_RESP, RD_ADDR and RD_DATA.
REQ-014 When the counter reaches TIMEOUT, the block SHALL drop all AXI valid/ready outputs, set rsp_resp=2'b11 and rsp_rdata=0, and go to RESP.
REQ-015 Input response codes SHALL pass through unmodified, including 2'b10 and 2'b11.

Reset
REQ-016 While axi_rstn is low, state SHALL be IDLE; cmd_ready SHALL be 1 (IDLE); all other outputs, registers and the counter SHALL be 0. This applies immediately and asynchronously, including mid-transaction.
REQ-017 After axi_rstn rises, the block SHALL accept a command on the first rising edge at which cmd_valid is high.

Verification
REQ-018 Write addr 3, data 1234, slave ready immediately -> AW and W valid for one cycle each, B OKAY -> rsp_valid, rsp_write=1, rsp_resp=0; slave reg[3]=1234.
REQ-019 Write with W ready 4 cycles after AW ready -> write_addr_valid drops after 1 cycle, write_data_valid held 5 cycles, single B.
REQ-020 Read addr 3 after REQ-018 -> AR single cycle; rsp_rdata=1234, rsp_write=0, rsp_resp=0.
REQ-021 TIMEOUT=8, read with read_addr_ready_i tied 0 -> after 8 cycles read_addr_valid_o=0, rsp_resp=2'b11, rsp_rdata=0.
REQ-022 rsp_ready held 0 for 6 cycles -> rsp_* stable and cmd_ready=0 throughout; IDLE after the handshake.
REQ-023 axi_rstn pulsed low during WR_RESP -> all valids 0 immediately, cmd_ready=1, and the next read completes normally.
